// File: rtl/serial_subtractor20.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first,
// and presents the difference, final borrow and signed overflow in a
// one-cycle done pulse. Results hold until the next completion or reset.
module serial_subtractor20 #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             ovf
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               br_q, br_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               b_out_q, b_out_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               ai_c;
  logic               bi_c;
  logic               diff_c;
  logic               borrow_c;

  // Full-subtractor cell on the current LSBs of the operand shifters
  always_comb begin
    ai_c     = a_sh_q[0];
    bi_c     = b_sh_q[0];
    diff_c   = ai_c ^ bi_c ^ br_q;
    borrow_c = (~ai_c & bi_c) | (~(ai_c ^ bi_c) & br_q);
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    d_d     = d_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = b_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
          busy_d  = 1'b1;
        end
      end

      SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d  = {diff_c, res_q[WIDTH-1:1]};
        br_d   = borrow_c;
        if (cnt_q == LAST_BIT) begin
          // br_q here is the borrow into the MSB; overflow is its XOR with borrow out
          state_d = DONE;
          done_d  = 1'b1;
          d_d     = {diff_c, res_q[WIDTH-1:1]};
          b_out_d = borrow_c;
          ovf_d   = br_q ^ borrow_c;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      d_q     <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      d_q     <= d_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign d     = d_q;
  assign b_out = b_out_q;
  assign ovf   = ovf_q;

endmodule
